// File: rtl/period_decoder.sv
// -----------------------------------------------------------------------------
// period_decoder
//
// Measures the spacing between two successive carry pulses from the
// programmable 128-modulus divider. From that spacing it recovers the 4-bit
// divide code n that produced them. Only cycles with cen=1 are counted or
// sampled. A measurement is requested with start, completes with a one-cycle
// done pulse, and leaves n_out/valid/err holding the decoded result until the
// next completion.
//
// Parameters
//   CW       measurement counter width
//   TIMEOUT  qualified-cycle count at which a measurement is abandoned
//            (must not exceed 2^CW-1 so the counter never wraps)
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   cen       in   count enable; cen=0 cycles freeze all measurement state
//   pulse_in  in   divider carry pulse, sampled only when cen=1
//   start     in   request one measurement, honoured only in IDLE
//   n_out     out  decoded divide code (4 bits)
//   valid     out  last measurement decoded to a legal code
//   err       out  last measurement illegal or timed out
//   busy      out  measurement in progress (ARM or MEASURE)
//   done      out  one-cycle pulse on measurement completion
// -----------------------------------------------------------------------------
module period_decoder #(
    parameter int CW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       pulse_in,
    input  logic       start,
    output logic [3:0] n_out,
    output logic       valid,
    output logic       err,
    output logic       busy,
    output logic       done
);

    // Completion returns straight to IDLE, so a start held high through the
    // done cycle re-arms one edge after the closing pulse. The done pulse is
    // therefore carried by its own register rather than by a separate state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [CW-1:0] period_s;
    logic          qp_s;
    logic          finish_s;
    logic          timeout_s;
    logic [5:0]    result_s;

    // Decode a period into {valid, err, n}. Period 128 is the n=0 wrap case.
    function automatic logic [5:0] decode_period(input logic [CW-1:0] p);
        logic [5:0] r;
        if (p == CW'(128)) begin
            r = {1'b1, 1'b0, 4'd0};
        end else if ((p >= CW'(8)) && (p <= CW'(120)) && (p[2:0] == 3'd0)) begin
            r = {1'b1, 1'b0, p[6:3]};
        end else begin
            r = {1'b0, 1'b1, 4'd0};
        end
        return r;
    endfunction

    assign qp_s = pulse_in & cen;

    // Next-state and counter logic; cen=0 freezes everything.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        finish_s  = 1'b0;
        timeout_s = 1'b0;
        // P includes the cycle carrying the closing pulse.
        period_s  = cnt_r + CW'(1);
        if (cen) begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s = ARM;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ARM: begin
                    if (qp_s) begin
                        state_s = MEASURE;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        state_s = ARM;
                    end
                end
                MEASURE: begin
                    cnt_s = period_s;
                    // A closing pulse wins over a simultaneous timeout.
                    if (qp_s) begin
                        finish_s = 1'b1;
                        state_s  = IDLE;
                    end else if (period_s == CW'(TIMEOUT)) begin
                        finish_s  = 1'b1;
                        timeout_s = 1'b1;
                        state_s   = IDLE;
                    end else begin
                        state_s = MEASURE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Result selection: timeout overrides the period decode.
    always_comb begin
        result_s = timeout_s ? {1'b0, 1'b1, 4'd0} : decode_period(period_s);
    end

    // State and measurement counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered outputs; results change only on a completed measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_out <= 4'd0;
            valid <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= finish_s;
            busy <= (state_s == ARM) || (state_s == MEASURE);
            if (finish_s) begin
                valid <= result_s[5];
                err   <= result_s[4];
                n_out <= result_s[3:0];
            end else begin
                valid <= valid;
                err   <= err;
                n_out <= n_out;
            end
        end
    end

endmodule

// File: tb/tb_period_decoder.sv
module tb_period_decoder;

    logic       clk;
    logic       rst;
    logic       cen;
    logic       pulse_in;
    logic       start;
    logic [3:0] n_out;
    logic       valid;
    logic       err;
    logic       busy;
    logic       done;

    int checks;
    int errors;
    int prev_n;
    int prev_v;
    int prev_e;

    period_decoder #(.CW(8), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .cen(cen), .pulse_in(pulse_in), .start(start),
        .n_out(n_out), .valid(valid), .err(err), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int period;
        bit gaps;
        int n;
        bit v;
        bit e;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, advance one rising edge, settle 1 time unit after it.
    task automatic step(input logic c, input logic p, input logic s);
        cen      = c;
        pulse_in = p;
        start    = s;
        @(posedge clk);
        #1;
    endtask

    // Reference decode from the period rules, written as plain arithmetic.
    task automatic model(input int p, output int n, output bit v, output bit e);
        if (p == 128) begin
            n = 0; v = 1'b1; e = 1'b0;
        end else if (p >= 8 && p <= 120 && (p % 8) == 0) begin
            n = p / 8; v = 1'b1; e = 1'b0;
        end else begin
            n = 0; v = 1'b0; e = 1'b1;
        end
    endtask

    // One full measurement: pulses p qualified cycles apart (p > 255 means
    // the second pulse never comes, so the 255-cycle timeout fires).
    task automatic measure(input int p, input bit gaps, input bit poke, input bit hold,
                           input int en, input bit ev, input bit ee);
        int  q;
        int  limit;
        int  guard;
        bit  c;
        bit  pl;
        bit  sv;
        limit = (p > 255) ? 255 : p;
        step(1'b1, 1'b0, 1'b1);
        chk("busy_after_start", busy, 1);
        chk("n_held_on_start", n_out, prev_n);
        chk("valid_held_on_start", valid, prev_v);
        chk("err_held_on_start", err, prev_e);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("arm_busy", busy, 1);
        chk("arm_no_done", done, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("measure_busy", busy, 1);
        q = 0;
        guard = 0;
        while (q < limit && guard < 3000) begin
            guard++;
            c = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (c) q++;
            pl = c ? (q == p) : ($urandom_range(0, 1) == 1);
            sv = poke && c && (q == limit / 2);
            step(c, pl, sv);
            if (q < limit) begin
                chk("no_early_done", done, 0);
            end
        end
        chk("loop_bound", guard < 3000, 1);
        chk("done_pulse", done, 1);
        chk("busy_low_at_done", busy, 0);
        chk("n_out", n_out, en);
        chk("valid", valid, ev);
        chk("err", err, ee);
        step(1'b1, 1'b0, hold);
        chk("done_drops", done, 0);
        chk("busy_after_done", busy, hold ? 1 : 0);
        chk("n_out_held", n_out, en);
        prev_n = en;
        prev_v = ev;
        prev_e = ee;
    endtask

    initial begin
        int n;
        bit v;
        bit e;
        int p;
        checks   = 0;
        errors   = 0;
        prev_n   = 0;
        prev_v   = 0;
        prev_e   = 0;
        rst      = 1'b1;
        cen      = 1'b0;
        pulse_in = 1'b0;
        start    = 1'b0;

        tbl[0]  = '{40,  1'b0, 5,  1'b1, 1'b0};
        tbl[1]  = '{128, 1'b0, 0,  1'b1, 1'b0};
        tbl[2]  = '{120, 1'b0, 15, 1'b1, 1'b0};
        tbl[3]  = '{43,  1'b0, 0,  1'b0, 1'b1};
        tbl[4]  = '{4,   1'b0, 0,  1'b0, 1'b1};
        tbl[5]  = '{24,  1'b1, 3,  1'b1, 1'b0};
        tbl[6]  = '{8,   1'b0, 1,  1'b1, 1'b0};
        tbl[7]  = '{121, 1'b0, 0,  1'b0, 1'b1};
        tbl[8]  = '{1,   1'b0, 0,  1'b0, 1'b1};
        tbl[9]  = '{300, 1'b0, 0,  1'b0, 1'b1};
        tbl[10] = '{255, 1'b0, 0,  1'b0, 1'b1};
        tbl[11] = '{16,  1'b1, 2,  1'b1, 1'b0};

        #3;
        chk("rst_n_out", n_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pulses while IDLE without start must do nothing.
        step(1'b1, 1'b1, 1'b0);
        chk("idle_ignores_pulse_busy", busy, 0);
        chk("idle_ignores_pulse_done", done, 0);

        for (int i = 0; i < 12; i++) begin
            measure(tbl[i].period, tbl[i].gaps, 1'b0, 1'b0, tbl[i].n, tbl[i].v, tbl[i].e);
        end

        // start pulsed mid-MEASURE is ignored; count undisturbed.
        measure(40, 1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0);

        // Back-to-back: start held across completion re-arms immediately.
        measure(32, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0);
        measure(48, 1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b0);

        // Reset in the middle of a measurement.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_n_out", n_out, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_err", err, 0);
        chk("midrst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, (i % 8) == 5, 1'b0);
            chk("postrst_no_done", done, 0);
            chk("postrst_idle", busy, 0);
        end
        prev_n = 0;
        prev_v = 0;
        prev_e = 0;

        // Randomized measurements against the arithmetic model.
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) p = $urandom_range(1, 300);
            else p = $urandom_range(1, 16) * 8;
            model(p, n, v, e);
            measure(p, $urandom_range(0, 1) == 1, 1'b0, 1'b0, n, v, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
